// File: rtl/signal_ctrl.sv
// signal_ctrl: vehicle turn / brake / hazard signal controller.
//
// Turn dwells and brake dwells are measured in timer ticks, where a tick is
// CLK_DIV clock cycles long. A brake request interrupts the current turn or
// hazard mode and, when the brake dwell ends, the interrupted context
// (mode plus remaining ticks) is restored. Turn requests, and hazard toggles,
// that arrive during BRAKE retarget the context that will be restored.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   en            synchronous master enable; 0 forces IDLE and clears context
//   left_pulse    one-cycle left-turn request
//   right_pulse   one-cycle right-turn request
//   brake_pulse   one-cycle brake request
//   hazard_pulse  one-cycle hazard toggle request
//   state         current mode (IDLE=0, LEFT=1, RIGHT=2, BRAKE=3, HAZARD=4)
//   remaining     ticks left in the current LEFT/RIGHT/BRAKE dwell, else 0
//   blink         flasher phase, 0 outside LEFT/RIGHT/HAZARD
//   expired       one-cycle strobe when a dwell times out
module signal_ctrl #(
  parameter int CLK_DIV     = 50000000,
  parameter int BLINK_DIV   = 25000000,
  parameter int CNT_W       = 8,
  parameter int TURN_TICKS  = 10,
  parameter int BRAKE_TICKS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             left_pulse,
  input  logic             right_pulse,
  input  logic             brake_pulse,
  input  logic             hazard_pulse,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remaining,
  output logic             blink,
  output logic             expired
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LEFT   = 3'b001,
    RIGHT  = 3'b010,
    BRAKE  = 3'b011,
    HAZARD = 3'b100
  } mode_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0]    BLINK_MAX  = BW'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_TICKS);
  localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_TICKS);

  mode_t            mode;
  mode_t            saved;
  mode_t            nsaved;
  mode_t            req_dir;
  logic [CNT_W-1:0] saved_rem;
  logic [CNT_W-1:0] nsaved_rem;
  logic [PW-1:0]    presc;
  logic [BW-1:0]    bcnt;
  logic             tick;
  logic             last;
  logic             flashing;
  logic             timed;
  logic             turn_req;

  assign state    = mode;
  assign tick     = (presc == PRESC_MAX);
  assign last     = tick && (remaining == CNT_W'(1));
  assign flashing = (mode == LEFT) || (mode == RIGHT) || (mode == HAZARD);
  assign timed    = (mode == LEFT) || (mode == RIGHT) || (mode == BRAKE);
  assign turn_req = left_pulse | right_pulse;
  // Right outranks left when both arrive together.
  assign req_dir  = right_pulse ? RIGHT : LEFT;

  // Context that BRAKE will restore after this cycle's non-brake pulses.
  // Computed separately so a pulse landing on the brake timeout edge is
  // honoured by the restore on that same edge.
  always_comb begin
    nsaved     = saved;
    nsaved_rem = saved_rem;
    if (hazard_pulse) begin
      nsaved     = (saved == HAZARD) ? IDLE : HAZARD;
      nsaved_rem = '0;
    end else if (turn_req) begin
      nsaved     = req_dir;
      nsaved_rem = TURN_LOAD;
    end
  end

  // Mode FSM with dwell timer, prescaler and flasher. Counter advance is
  // written first as a default; mode-change branches below override it
  // because the later non-blocking assignment wins. Pulses take precedence
  // over a coincident tick in LEFT/RIGHT, so a late re-request never strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= IDLE;
      saved     <= IDLE;
      saved_rem <= '0;
      remaining <= '0;
      presc     <= '0;
      bcnt      <= '0;
      blink     <= 1'b0;
      expired   <= 1'b0;
    end else if (!en) begin
      mode      <= IDLE;
      saved     <= IDLE;
      saved_rem <= '0;
      remaining <= '0;
      presc     <= '0;
      bcnt      <= '0;
      blink     <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;

      if (flashing) begin
        if (bcnt == BLINK_MAX) begin
          blink <= ~blink;
          bcnt  <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      if (timed) begin
        presc <= tick ? '0 : presc + 1'b1;
      end else begin
        presc <= '0;
      end

      case (mode)
        IDLE: begin
          if (brake_pulse) begin
            saved     <= IDLE;
            saved_rem <= '0;
            mode      <= BRAKE;
            remaining <= BRAKE_LOAD;
            presc     <= '0;
          end else if (hazard_pulse) begin
            mode      <= HAZARD;
            remaining <= '0;
            blink     <= 1'b1;
            bcnt      <= '0;
          end else if (turn_req) begin
            mode      <= req_dir;
            remaining <= TURN_LOAD;
            presc     <= '0;
            blink     <= 1'b1;
            bcnt      <= '0;
          end
        end

        LEFT, RIGHT: begin
          if (brake_pulse) begin
            saved     <= mode;
            saved_rem <= remaining;
            mode      <= BRAKE;
            remaining <= BRAKE_LOAD;
            presc     <= '0;
            blink     <= 1'b0;
            bcnt      <= '0;
          end else if (hazard_pulse) begin
            mode      <= HAZARD;
            remaining <= '0;
            presc     <= '0;
            blink     <= 1'b1;
            bcnt      <= '0;
          end else if (turn_req) begin
            // Same direction only reloads the dwell; the flasher keeps phase.
            remaining <= TURN_LOAD;
            presc     <= '0;
            if (req_dir != mode) begin
              mode  <= req_dir;
              blink <= 1'b1;
              bcnt  <= '0;
            end
          end else if (last) begin
            mode      <= IDLE;
            remaining <= '0;
            presc     <= '0;
            blink     <= 1'b0;
            bcnt      <= '0;
            expired   <= 1'b1;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end

        BRAKE: begin
          if (brake_pulse) begin
            remaining <= BRAKE_LOAD;
            presc     <= '0;
          end else begin
            saved     <= nsaved;
            saved_rem <= nsaved_rem;
            if (last) begin
              mode      <= nsaved;
              remaining <= (nsaved == IDLE) ? '0 : nsaved_rem;
              presc     <= '0;
              expired   <= 1'b1;
              saved     <= IDLE;
              saved_rem <= '0;
              if (nsaved != IDLE) begin
                blink <= 1'b1;
                bcnt  <= '0;
              end
            end else if (tick) begin
              remaining <= remaining - 1'b1;
            end
          end
        end

        HAZARD: begin
          if (brake_pulse) begin
            saved     <= HAZARD;
            saved_rem <= '0;
            mode      <= BRAKE;
            remaining <= BRAKE_LOAD;
            presc     <= '0;
            blink     <= 1'b0;
            bcnt      <= '0;
          end else if (hazard_pulse) begin
            mode  <= IDLE;
            blink <= 1'b0;
            bcnt  <= '0;
          end
        end

        default: begin
          mode      <= IDLE;
          remaining <= '0;
          blink     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_ctrl.sv
// tb_signal_ctrl: self-checking bench for signal_ctrl in its small test
// configuration. Directed vector table, hand-written multi-cycle sequences,
// and randomized traffic compared against a behavioural model that tracks
// elapsed cycles since each dwell load and since each flasher start.
module tb_signal_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;
  localparam int CNT_W     = 8;
  localparam int TURN      = 3;
  localparam int BRAKE_T   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             left_pulse = 1'b0;
  logic             right_pulse = 1'b0;
  logic             brake_pulse = 1'b0;
  logic             hazard_pulse = 1'b0;
  logic [2:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             blink;
  logic             expired;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    bit en;
    bit lp;
    bit rp;
    bit bp;
    bit hp;
    int st;
    int rem;
    bit bl;
    bit ex;
  } vec_t;

  vec_t vecs[$];

  // Reference model: mode as int, dwell measured in elapsed cycles.
  int m_mode, m_rem, m_saved, m_srem, m_t, m_bage;
  bit m_exp;

  always #5 clk = ~clk;

  signal_ctrl #(
    .CLK_DIV(CLK_DIV),
    .BLINK_DIV(BLINK_DIV),
    .CNT_W(CNT_W),
    .TURN_TICKS(TURN),
    .BRAKE_TICKS(BRAKE_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .brake_pulse(brake_pulse),
    .hazard_pulse(hazard_pulse),
    .state(state),
    .remaining(remaining),
    .blink(blink),
    .expired(expired)
  );

  task automatic modelReset();
    m_mode = 0; m_rem = 0; m_saved = 0; m_srem = 0;
    m_t = 0; m_bage = 0; m_exp = 0;
  endtask

  task automatic enter(input int md, input int rm);
    m_mode = md; m_rem = rm; m_t = 0; m_bage = 0;
  endtask

  function automatic bit modelBlink();
    if (m_mode == 1 || m_mode == 2 || m_mode == 4)
      return ((m_bage / BLINK_DIV) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic modelStep(input bit e, input bit l, input bit r, input bit b, input bit h);
    bit timed, tick;
    int dir;
    m_exp = 0;
    if (!e) begin
      modelReset();
      return;
    end
    timed = (m_mode >= 1 && m_mode <= 3);
    tick = timed && (((m_t + 1) % CLK_DIV) == 0);
    m_t = timed ? m_t + 1 : 0;
    m_bage++;
    dir = r ? 2 : (l ? 1 : 0);
    case (m_mode)
      0: begin
        if (b) begin m_saved = 0; m_srem = 0; enter(3, BRAKE_T); end
        else if (h) enter(4, 0);
        else if (dir != 0) enter(dir, TURN);
      end
      1, 2: begin
        if (b) begin m_saved = m_mode; m_srem = m_rem; enter(3, BRAKE_T); end
        else if (h) enter(4, 0);
        else if (dir == m_mode) begin m_rem = TURN; m_t = 0; end
        else if (dir != 0) enter(dir, TURN);
        else if (tick) begin
          if (m_rem == 1) begin enter(0, 0); m_exp = 1; end
          else m_rem--;
        end
      end
      3: begin
        if (b) begin m_rem = BRAKE_T; m_t = 0; end
        else begin
          if (h) begin m_saved = (m_saved == 4) ? 0 : 4; m_srem = 0; end
          else if (dir != 0) begin m_saved = dir; m_srem = TURN; end
          if (tick) begin
            if (m_rem == 1) begin
              enter(m_saved, (m_saved == 0) ? 0 : m_srem);
              m_exp = 1; m_saved = 0; m_srem = 0;
            end else m_rem--;
          end
        end
      end
      default: begin
        if (b) begin m_saved = 4; m_srem = 0; enter(3, BRAKE_T); end
        else if (h) enter(0, 0);
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input int es, input int er, input bit eb, input bit ee);
    checkCount++;
    if (state === 3'(es) && remaining === CNT_W'(er) && blink === eb && expired === ee)
      passCount++;
    else
      $display("[TB] FAIL %s: got state=%0d rem=%0d blink=%0b exp=%0b, expected state=%0d rem=%0d blink=%0b exp=%0b",
               name, state, remaining, blink, expired, es, er, eb, ee);
  endtask

  task automatic applyStimulus(input bit e, input bit l, input bit r, input bit b, input bit h);
    @(negedge clk);
    en = e; left_pulse = l; right_pulse = r; brake_pulse = b; hazard_pulse = h;
    @(posedge clk);
    modelStep(e, l, r, b, h);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0);
  endtask

  task automatic releaseReset(input bit l, input bit r, input bit b, input bit h);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    left_pulse = l; right_pulse = r; brake_pulse = b; hazard_pulse = h;
    @(posedge clk);
    modelStep(1, l, r, b, h);
    #1;
  endtask

  function automatic void addVec(bit e, bit l, bit r, bit b, bit h, int st, int rem, bit bl, bit ex);
    vecs.push_back('{e, l, r, b, h, st, rem, bl, ex});
  endfunction

  initial begin
    // Left dwell: ticks every 4 cycles, timeout 12 cycles after entry.
    addVec(1,1,0,0,0, 1,3,1,0);
    addVec(1,0,0,0,0, 1,3,1,0);
    addVec(1,0,0,0,0, 1,3,0,0);
    addVec(1,0,0,0,0, 1,3,0,0);
    addVec(1,0,0,0,0, 1,2,1,0);
    addVec(1,0,0,0,0, 1,2,1,0);
    addVec(1,0,0,0,0, 1,2,0,0);
    addVec(1,0,0,0,0, 1,2,0,0);
    addVec(1,0,0,0,0, 1,1,1,0);
    addVec(1,0,0,0,0, 1,1,1,0);
    addVec(1,0,0,0,0, 1,1,0,0);
    addVec(1,0,0,0,0, 1,1,0,0);
    addVec(1,0,0,0,0, 0,0,0,1);
    addVec(1,0,0,0,0, 0,0,0,0);
    // Hazard: blink every 2 cycles, left ignored, second hazard exits.
    addVec(1,0,0,0,1, 4,0,1,0);
    addVec(1,1,0,0,0, 4,0,1,0);
    addVec(1,0,0,0,0, 4,0,0,0);
    addVec(1,0,0,0,0, 4,0,0,0);
    addVec(1,0,0,0,0, 4,0,1,0);
    addVec(1,0,0,0,1, 0,0,0,0);
    // Simultaneous left+right+brake from IDLE: brake, back to IDLE.
    addVec(1,1,1,1,0, 3,2,0,0);
    addVec(1,0,0,0,0, 3,2,0,0);
    addVec(1,0,0,0,0, 3,2,0,0);
    addVec(1,0,0,0,0, 3,2,0,0);
    addVec(1,0,0,0,0, 3,1,0,0);
    addVec(1,0,0,0,0, 3,1,0,0);
    addVec(1,0,0,0,0, 3,1,0,0);
    addVec(1,0,0,0,0, 3,1,0,0);
    addVec(1,0,0,0,0, 0,0,0,1);
    addVec(1,0,0,0,0, 0,0,0,0);
    // Direction switch restarts blink at 1; en low clears.
    addVec(1,1,0,0,0, 1,3,1,0);
    addVec(1,0,0,0,0, 1,3,1,0);
    addVec(1,0,0,0,0, 1,3,0,0);
    addVec(1,0,1,0,0, 2,3,1,0);
    addVec(1,0,0,0,0, 2,3,1,0);
    addVec(0,0,0,0,0, 0,0,0,0);
    addVec(1,1,1,0,0, 2,3,1,0);
    addVec(0,0,0,0,0, 0,0,0,0);

    modelReset();
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    en = 1'b1; left_pulse = 1'b1;
    @(posedge clk);
    #1 checkOutput("reset_ignores_pulse", 0, 0, 0, 0);
    releaseReset(0, 0, 0, 0);
    checkOutput("reset_release", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].lp, vecs[i].rp, vecs[i].bp, vecs[i].hp);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].rem, vecs[i].bl, vecs[i].ex);
    end

    // Brake interrupts left at remaining=2, then restores it.
    applyStimulus(1, 1, 0, 0, 0);
    idle(4);
    checkOutput("s40_pre", 1, 2, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("s40_brake", 3, 2, 0, 0);
    idle(7);
    checkOutput("s40_brake_end", 3, 1, 0, 0);
    idle(1);
    checkOutput("s40_restore", 1, 2, 1, 1);
    idle(7);
    checkOutput("s40_tail", 1, 1, 0, 0);
    idle(1);
    checkOutput("s40_idle", 0, 0, 0, 1);

    // Right re-request one cycle before timeout.
    applyStimulus(1, 0, 1, 0, 0);
    idle(11);
    checkOutput("s43_pre", 2, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("s43_restart", 2, 3, 1, 0);
    idle(1);
    checkOutput("s43_after", 2, 3, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Hazard toggle during brake restores HAZARD; left during brake restores LEFT.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("brk_haz_toggle", 3, 2, 0, 0);
    idle(7);
    checkOutput("brk_restore_haz", 4, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0);
    idle(7);
    checkOutput("brk_restore_left", 1, 3, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // en drop during brake, then async reset mid-left.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("s44_brake", 3, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s44_en_low", 0, 0, 0, 0);
    idle(10);
    checkOutput("s44_no_restore", 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    idle(2);
    #2 rst = 1'b1;
    #1 checkOutput("s44_async_rst", 0, 0, 0, 0);
    modelReset();
    releaseReset(0, 1, 0, 0);
    checkOutput("release_with_pulse", 2, 3, 1, 0);

    // Randomized traffic against the model, from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    modelReset();
    releaseReset(0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 49) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 13) == 0,
                    $urandom_range(0, 9) == 0);
      checkOutput($sformatf("rand%0d", i), m_mode, m_rem, modelBlink(), m_exp);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
